// File: rtl/branch_resolve_unit_pkg.sv
// Shared types for the branch resolve unit: operation encoding, ROB index and
// the resolution record handed to the frontend.
package branch_resolve_unit_pkg;

   localparam int unsigned BU_XLEN      = 64;
   localparam int unsigned BU_RES_DEPTH = 4;
   localparam int unsigned ROB_IDX_W    = 4;

   typedef logic [ROB_IDX_W-1:0] rob_idx_t;

   typedef enum logic [3:0] {
      BU_BEQ  = 4'd0,
      BU_BNE  = 4'd1,
      BU_BLT  = 4'd2,
      BU_BGE  = 4'd3,
      BU_BLTU = 4'd4,
      BU_BGEU = 4'd5,
      BU_JAL  = 4'd6,
      BU_JALR = 4'd7
   } branch_ctl_t;

   typedef struct packed {
      logic [BU_XLEN-1:0] pc;
      logic [BU_XLEN-1:0] target;
      logic               taken;
      logic               mispredict;
   } resolution_t;

endpackage

// File: rtl/branch_resolve_unit_res_fifo.sv
// Circular resolution buffer: power-of-two depth, same-cycle push/pop allowed
// even when full, synchronous flush clears pointers and occupancy.
module branch_res_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = 8
) (
   input  logic                         clk_i,
   input  logic                         rst_n_i,
   input  logic                         flush_i,
   input  logic                         push_i,
   input  logic [W-1:0]                 data_i,
   input  logic                         pop_i,
   output logic [W-1:0]                 data_o,
   output logic                         valid_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [W-1:0]     mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;

   // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else if (flush_i) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         wr_ptr_r <= push_i ? wr_ptr_r + PTR_W'(1'b1) : wr_ptr_r;
         rd_ptr_r <= pop_i  ? rd_ptr_r + PTR_W'(1'b1) : rd_ptr_r;
         case ({push_i, pop_i})
            2'b10:   count_r <= count_r + CNT_W'(1'b1);
            2'b01:   count_r <= count_r - CNT_W'(1'b1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Entry storage carries no reset; occupancy alone qualifies the head.
   always_ff @(posedge clk_i) begin
      if (push_i) begin
         mem_r[wr_ptr_r] <= data_i;
      end else begin
         mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
      end
   end

   assign data_o  = mem_r[rd_ptr_r];
   assign valid_o = (count_r != '0);
   assign count_o = count_r;

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch execution unit: resolves branches/JAL/JALR, one-entry CDB output register
// and a resolution FIFO to the frontend. Macro LEN5_C_EN enables compressed-ISA links.
module branch_resolve_unit
   import branch_resolve_unit_pkg::*;
#(
   parameter int unsigned XLEN_P    = BU_XLEN,
   parameter int unsigned RES_DEPTH = BU_RES_DEPTH,
   parameter bit          RES_ALL   = 1'b0
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              flush_i,
   input  logic              op_valid_i,
   output logic              op_ready_o,
   input  branch_ctl_t       op_type_i,
   input  logic [XLEN_P-1:0] op_rs1_i,
   input  logic [XLEN_P-1:0] op_rs2_i,
   input  logic [XLEN_P-1:0] op_imm_i,
   input  logic [XLEN_P-1:0] op_pc_i,
   input  logic [XLEN_P-1:0] op_pred_target_i,
   input  logic              op_pred_taken_i,
   input  logic              op_compr_i,
   input  rob_idx_t          op_rob_idx_i,
   output logic              cdb_valid_o,
   input  logic              cdb_ready_i,
   output rob_idx_t          cdb_rob_idx_o,
   output logic [XLEN_P-1:0] cdb_link_o,
   output logic              cdb_mis_o,
   output logic              cdb_except_o,
   output logic              fe_res_valid_o,
   input  logic              fe_ready_i,
   output resolution_t       fe_res_o,
   output logic              mis_pending_o
);

   localparam int unsigned CNT_W = $clog2(RES_DEPTH + 1);
   localparam int unsigned RES_W = $bits(resolution_t);

   logic              taken_s, type_ok_s, is_jalr_s, mis_s, except_s;
   logic [XLEN_P-1:0] sum_s, target_s, link_s;
   logic              hs_s, push_s, pop_s, fifo_valid_s;
   logic [CNT_W-1:0]  fifo_count_s, mis_cnt_r;
   logic [RES_W-1:0]  fifo_dout_s;
   resolution_t       res_in_s, res_out_s;
   logic              cdb_valid_r, cdb_mis_r, cdb_except_r;
   rob_idx_t          cdb_rob_idx_r;
   logic [XLEN_P-1:0] cdb_link_r;

   // Branch condition; unrecognised encodings resolve not-taken and never enqueue.
   always_comb begin
      taken_s   = 1'b0;
      type_ok_s = 1'b1;
      case (op_type_i)
         BU_BEQ:          taken_s = (op_rs1_i == op_rs2_i);
         BU_BNE:          taken_s = (op_rs1_i != op_rs2_i);
         BU_BLT:          taken_s = ($signed(op_rs1_i) <  $signed(op_rs2_i));
         BU_BGE:          taken_s = ($signed(op_rs1_i) >= $signed(op_rs2_i));
         BU_BLTU:         taken_s = (op_rs1_i <  op_rs2_i);
         BU_BGEU:         taken_s = (op_rs1_i >= op_rs2_i);
         BU_JAL, BU_JALR: taken_s = 1'b1;
         default:         type_ok_s = 1'b0;
      endcase
   end

   assign is_jalr_s = (op_type_i == BU_JALR);
   assign sum_s     = op_imm_i + (is_jalr_s ? op_rs1_i : op_pc_i);
   assign target_s  = {sum_s[XLEN_P-1:1], sum_s[0] & ~is_jalr_s};
   assign mis_s     = (op_pred_taken_i != taken_s) |
                      (op_pred_taken_i & (op_pred_target_i != target_s));

`ifdef LEN5_C_EN
   assign link_s   = op_pc_i + (op_compr_i ? XLEN_P'(3'd2) : XLEN_P'(3'd4));
   assign except_s = 1'b0;
`else
   logic unused_compr_s;
   assign unused_compr_s = op_compr_i;
   assign link_s   = op_pc_i + XLEN_P'(3'd4);
   assign except_s = taken_s & target_s[1];
`endif

   // Readiness is deliberately independent of the offered op so the RS sees no comb loop.
   assign op_ready_o = (~cdb_valid_r | cdb_ready_i) &
                       ((fifo_count_s < CNT_W'(RES_DEPTH)) | fe_ready_i);
   assign hs_s   = op_valid_i & op_ready_o;
   assign push_s = hs_s & type_ok_s & (RES_ALL | mis_s) & ~flush_i;
   assign pop_s  = fe_ready_i & fifo_valid_s & ~flush_i;

   // Pack the resolution record at the frontend's address width.
   always_comb begin
      res_in_s            = '0;
      res_in_s.pc         = BU_XLEN'(op_pc_i);
      res_in_s.target     = BU_XLEN'(target_s);
      res_in_s.taken      = taken_s;
      res_in_s.mispredict = mis_s;
   end

   // One-entry CDB register: holds under back-pressure, loads and drains in one cycle.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cdb_valid_r   <= 1'b0;
         cdb_rob_idx_r <= '0;
         cdb_link_r    <= '0;
         cdb_mis_r     <= 1'b0;
         cdb_except_r  <= 1'b0;
      end else if (flush_i) begin
         cdb_valid_r   <= 1'b0;
      end else if (hs_s) begin
         cdb_valid_r   <= 1'b1;
         cdb_rob_idx_r <= op_rob_idx_i;
         cdb_link_r    <= link_s;
         cdb_mis_r     <= mis_s;
         cdb_except_r  <= except_s;
      end else if (cdb_ready_i) begin
         cdb_valid_r   <= 1'b0;
      end else begin
         cdb_valid_r   <= cdb_valid_r;
      end
   end

   branch_res_fifo #(
      .DEPTH (RES_DEPTH),
      .W     (RES_W)
   ) u_res_fifo (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .flush_i (flush_i),
      .push_i  (push_s),
      .data_i  (res_in_s),
      .pop_i   (pop_s),
      .data_o  (fifo_dout_s),
      .valid_o (fifo_valid_s),
      .count_o (fifo_count_s)
   );

   assign res_out_s = resolution_t'(fifo_dout_s);

   // Mispredicted entries currently queued; drives the issue stall.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         mis_cnt_r <= '0;
      end else if (flush_i) begin
         mis_cnt_r <= '0;
      end else begin
         case ({push_s & mis_s, pop_s & res_out_s.mispredict})
            2'b10:   mis_cnt_r <= mis_cnt_r + CNT_W'(1'b1);
            2'b01:   mis_cnt_r <= mis_cnt_r - CNT_W'(1'b1);
            default: mis_cnt_r <= mis_cnt_r;
         endcase
      end
   end

   assign cdb_valid_o    = cdb_valid_r;
   assign cdb_rob_idx_o  = cdb_rob_idx_r;
   assign cdb_link_o     = cdb_link_r;
   assign cdb_mis_o      = cdb_mis_r;
   assign cdb_except_o   = cdb_except_r;
   assign fe_res_valid_o = fifo_valid_s;
   assign fe_res_o       = res_out_s;
   assign mis_pending_o  = (mis_cnt_r != '0);

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit (XLEN_P=64, RES_DEPTH=4, RES_ALL=0).
module tb_branch_resolve_unit;
   import branch_resolve_unit_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_n_i, flush_i, op_valid_i, op_ready_o;
   branch_ctl_t op_type_i;
   logic [63:0] op_rs1_i, op_rs2_i, op_imm_i, op_pc_i, op_pred_target_i;
   logic        op_pred_taken_i, op_compr_i;
   rob_idx_t    op_rob_idx_i, cdb_rob_idx_o;
   logic        cdb_valid_o, cdb_ready_i, cdb_mis_o, cdb_except_o;
   logic [63:0] cdb_link_o;
   logic        fe_res_valid_o, fe_ready_i, mis_pending_o;
   resolution_t fe_res_o;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk_i = ~clk_i;

   branch_resolve_unit #(.XLEN_P(64), .RES_DEPTH(4), .RES_ALL(1'b0)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i),
      .op_valid_i(op_valid_i), .op_ready_o(op_ready_o), .op_type_i(op_type_i),
      .op_rs1_i(op_rs1_i), .op_rs2_i(op_rs2_i), .op_imm_i(op_imm_i), .op_pc_i(op_pc_i),
      .op_pred_target_i(op_pred_target_i), .op_pred_taken_i(op_pred_taken_i),
      .op_compr_i(op_compr_i), .op_rob_idx_i(op_rob_idx_i),
      .cdb_valid_o(cdb_valid_o), .cdb_ready_i(cdb_ready_i), .cdb_rob_idx_o(cdb_rob_idx_o),
      .cdb_link_o(cdb_link_o), .cdb_mis_o(cdb_mis_o), .cdb_except_o(cdb_except_o),
      .fe_res_valid_o(fe_res_valid_o), .fe_ready_i(fe_ready_i), .fe_res_o(fe_res_o),
      .mis_pending_o(mis_pending_o)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_op(input branch_ctl_t t, input logic [63:0] rs1, input logic [63:0] rs2,
                         input logic [63:0] imm, input logic [63:0] pc, input logic [63:0] ptgt,
                         input logic ptaken, input logic compr, input rob_idx_t rob);
      op_valid_i = 1'b1; op_type_i = t; op_rs1_i = rs1; op_rs2_i = rs2; op_imm_i = imm;
      op_pc_i = pc; op_pred_target_i = ptgt; op_pred_taken_i = ptaken;
      op_compr_i = compr; op_rob_idx_i = rob;
   endtask

   // Wait (bounded) for op_ready_o, take the handshake edge, then drop op_valid_i.
   task automatic fire();
      int n = 0;
      #1;
      while (!op_ready_o && n < 20) begin
         tick();
         n++;
      end
      if (!op_ready_o) check_eq("hs_timeout", {63'd0, op_ready_o}, 64'd1);
      tick();
      op_valid_i = 1'b0;
   endtask

   initial begin
      rst_n_i = 1'b0; flush_i = 1'b0; op_valid_i = 1'b0; cdb_ready_i = 1'b1; fe_ready_i = 1'b0;
      set_op(BU_BEQ, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 4'd0);
      op_valid_i = 1'b0;
      tick(); tick();
      check_eq("rst_cdb_valid", {63'd0, cdb_valid_o}, 64'd0);
      check_eq("rst_fe_valid", {63'd0, fe_res_valid_o}, 64'd0);
      check_eq("rst_mis_pend", {63'd0, mis_pending_o}, 64'd0);
      rst_n_i = 1'b1;
      tick();
      check_eq("rst_op_ready", {63'd0, op_ready_o}, 64'd1);

      // 1: correctly predicted BEQ
      set_op(BU_BEQ, 64'd5, 64'd5, 64'h20, 64'h100, 64'h120, 1'b1, 1'b0, 4'd3);
      fire();
      check_eq("t1_valid", {63'd0, cdb_valid_o}, 64'd1);
      check_eq("t1_mis", {63'd0, cdb_mis_o}, 64'd0);
      check_eq("t1_link", cdb_link_o, 64'h104);
      check_eq("t1_rob", {60'd0, cdb_rob_idx_o}, 64'd3);
      check_eq("t1_except", {63'd0, cdb_except_o}, 64'd0);
      check_eq("t1_no_push", {63'd0, fe_res_valid_o}, 64'd0);
      tick();
      check_eq("t1_drain", {63'd0, cdb_valid_o}, 64'd0);

      // BLTU with -1 vs 1 is not taken, predicted not taken
      set_op(BU_BLTU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h40, 64'h180, 64'd0, 1'b0, 1'b0, 4'd1);
      fire();
      check_eq("bltu_mis", {63'd0, cdb_mis_o}, 64'd0);
      check_eq("bltu_no_push", {63'd0, fe_res_valid_o}, 64'd0);

      // Unknown encoding predicted taken: mispredict but never enqueued
      set_op(branch_ctl_t'(4'd9), 64'd1, 64'd1, 64'h8, 64'h1C0, 64'h1C8, 1'b1, 1'b0, 4'd2);
      fire();
      check_eq("unk_no_push", {63'd0, fe_res_valid_o}, 64'd0);
      check_eq("unk_no_pend", {63'd0, mis_pending_o}, 64'd0);

      // 2: signed BLT taken, predicted not taken
      set_op(BU_BLT, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h40, 64'h200, 64'd0, 1'b0, 1'b0, 4'd4);
      fire();
      check_eq("t2_mis", {63'd0, cdb_mis_o}, 64'd1);
      check_eq("t2_fe_valid", {63'd0, fe_res_valid_o}, 64'd1);
      check_eq("t2_fe_target", fe_res_o.target, 64'h240);
      check_eq("t2_fe_pc", fe_res_o.pc, 64'h200);
      check_eq("t2_fe_taken", {63'd0, fe_res_o.taken}, 64'd1);
      check_eq("t2_pend", {63'd0, mis_pending_o}, 64'd1);
      tick(); tick();
      check_eq("t2_pend_hold", {63'd0, mis_pending_o}, 64'd1);
      fe_ready_i = 1'b1;
      tick();
      fe_ready_i = 1'b0;
      check_eq("t2_popped", {63'd0, fe_res_valid_o}, 64'd0);
      check_eq("t2_pend_clr", {63'd0, mis_pending_o}, 64'd0);

      // 3: JALR target bit0 cleared
      set_op(BU_JALR, 64'h1001, 64'd0, 64'h2, 64'h300, 64'h1002, 1'b1, 1'b1, 4'd5);
      fire();
      check_eq("t3_mis", {63'd0, cdb_mis_o}, 64'd0);
`ifdef LEN5_C_EN
      check_eq("t3_except", {63'd0, cdb_except_o}, 64'd0);
      check_eq("t3_link", cdb_link_o, 64'h302);
`else
      check_eq("t3_except", {63'd0, cdb_except_o}, 64'd1);
      check_eq("t3_link", cdb_link_o, 64'h304);
`endif

      // JAL predicted taken to the wrong target
      set_op(BU_JAL, 64'd0, 64'd0, 64'h10, 64'h400, 64'h414, 1'b1, 1'b0, 4'd6);
      fire();
      check_eq("jal_mis", {63'd0, cdb_mis_o}, 64'd1);
      check_eq("jal_fe_target", fe_res_o.target, 64'h410);
      fe_ready_i = 1'b1;
      tick();
      fe_ready_i = 1'b0;
      check_eq("jal_popped", {63'd0, mis_pending_o}, 64'd0);

      // 4: fill the FIFO, then push+pop on full
      for (int i = 0; i < 4; i++) begin
         set_op(BU_BNE, 64'd1, 64'd2, 64'h80, 64'h1000 + 64'(i) * 64'h10, 64'd0, 1'b0, 1'b0, 4'(i));
         fire();
      end
      check_eq("t4_full_ready", {63'd0, op_ready_o}, 64'd0);
      check_eq("t4_head", fe_res_o.pc, 64'h1000);
      set_op(BU_BNE, 64'd1, 64'd2, 64'h80, 64'h1040, 64'd0, 1'b0, 1'b0, 4'd4);
      #1;
      check_eq("t4_blocked", {63'd0, op_ready_o}, 64'd0);
      fe_ready_i = 1'b1;
      #1;
      check_eq("t4_unblock", {63'd0, op_ready_o}, 64'd1);
      tick();
      op_valid_i = 1'b0;
      fe_ready_i = 1'b0;
      check_eq("t4_head2", fe_res_o.pc, 64'h1010);
      check_eq("t4_pend", {63'd0, mis_pending_o}, 64'd1);
      fe_ready_i = 1'b1;
      for (int i = 2; i < 5; i++) begin
         tick();
         check_eq("t4_drain_pc", fe_res_o.pc, 64'h1000 + 64'(i) * 64'h10);
      end
      tick();
      fe_ready_i = 1'b0;
      check_eq("t4_empty", {63'd0, fe_res_valid_o}, 64'd0);
      check_eq("t4_pend_clr", {63'd0, mis_pending_o}, 64'd0);

      // 5: CDB back-pressure
      cdb_ready_i = 1'b0;
      set_op(BU_JAL, 64'd0, 64'd0, 64'h8, 64'h500, 64'h508, 1'b1, 1'b0, 4'd5);
      fire();
      set_op(BU_BEQ, 64'd7, 64'd7, 64'h10, 64'h600, 64'h610, 1'b1, 1'b0, 4'd6);
      for (int i = 0; i < 3; i++) begin
         #1;
         check_eq("t5_ready_low", {63'd0, op_ready_o}, 64'd0);
         check_eq("t5_link_hold", cdb_link_o, 64'h504);
         check_eq("t5_rob_hold", {60'd0, cdb_rob_idx_o}, 64'd5);
         tick();
      end
      cdb_ready_i = 1'b1;
      #1;
      check_eq("t5_release", {63'd0, op_ready_o}, 64'd1);
      tick();
      op_valid_i = 1'b0;
      check_eq("t5_new_rob", {60'd0, cdb_rob_idx_o}, 64'd6);
      check_eq("t5_new_link", cdb_link_o, 64'h604);
      check_eq("t5_valid", {63'd0, cdb_valid_o}, 64'd1);

      // 6: flush beats a same-cycle handshake
      for (int i = 0; i < 3; i++) begin
         set_op(BU_BNE, 64'd3, 64'd4, 64'h20, 64'h700 + 64'(i) * 64'h8, 64'd0, 1'b0, 1'b0, 4'(i));
         fire();
      end
      check_eq("t6_pre_pend", {63'd0, mis_pending_o}, 64'd1);
      set_op(BU_BNE, 64'd3, 64'd4, 64'h20, 64'h720, 64'd0, 1'b0, 1'b0, 4'd7);
      flush_i = 1'b1;
      tick();
      op_valid_i = 1'b0;
      flush_i = 1'b0;
      check_eq("t6_fe_valid", {63'd0, fe_res_valid_o}, 64'd0);
      check_eq("t6_pend", {63'd0, mis_pending_o}, 64'd0);
      check_eq("t6_cdb_valid", {63'd0, cdb_valid_o}, 64'd0);

      // Asynchronous reset mid-cycle discards queued state
      set_op(BU_BNE, 64'd3, 64'd4, 64'h20, 64'h800, 64'd0, 1'b0, 1'b0, 4'd1);
      fire();
      check_eq("ar_pre", {63'd0, fe_res_valid_o}, 64'd1);
      #2;
      rst_n_i = 1'b0;
      #1;
      check_eq("ar_cdb", {63'd0, cdb_valid_o}, 64'd0);
      check_eq("ar_fe", {63'd0, fe_res_valid_o}, 64'd0);
      check_eq("ar_pend", {63'd0, mis_pending_o}, 64'd0);
      tick();
      rst_n_i = 1'b1;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
